uart_cmd_parser: RTL and testbench

Byte-to-command parser sitting directly downstream of the UART receiver (RXD) inside the memory-mapped Top. It packs received bytes little-endian into 32-bit words and parses the host frame: a CMD word, a COUNT word, then COUNT (address, data) word pairs. For each pair it presents cmd/addr/data with a one-cycle `done` strobe to the memory-mapped write/read logic.

---
 rtl/uart_cmd_parser.sv | 185 ++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Packs bytes from the UART receiver little-endian into 32-bit words and
//   parses host frames of the form: CMD, COUNT, then COUNT (ADDR, DATA) pairs.
//   Each completed pair is presented on cmd/addr/data with a one-cycle done.
//
// Optional feature: define UART_CMD_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES idle clocks mid-frame (err pulse, return to S_CMD).
//
// Ports:
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   rx_data    in   8   received byte
//   rx_valid   in   1   rx_data valid strobe
//   cmd        out  32  CMD word of current frame
//   addr       out  32  address of current pair
//   data       out  32  data of current pair
//   done       out  1   strobe: cmd/addr/data hold a complete pair
//   frame_end  out  1   strobe: frame finished normally
//   busy       out  1   frame in progress
//   err        out  1   strobe: COUNT rejected or timeout
module uart_cmd_parser #(
  parameter int unsigned MAX_COUNT      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 52080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] cmd,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        done,
  output logic        frame_end,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] S_CMD   = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_ADDR  = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rem_q, rem_d;
  logic        done_q, done_d;
  logic        frame_end_q, frame_end_d;
  logic        err_q, err_d;

  // The word including the byte arriving this cycle; the FSM consumes this
  // directly so a completed word is acted on without an extra cycle.
  logic [31:0] word_next;
  logic        word_ok;
  logic        busy_w;

  assign word_next = {rx_data, word_q[31:8]};
  assign word_ok   = rx_valid && (idx_q == 2'd3);
  assign busy_w    = !((state_q == S_CMD) && (idx_q == 2'd0));

`ifdef UART_CMD_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        tmo_expire;

  // Expiry is the cycle the idle count would reach TIMEOUT_CYCLES; a byte
  // arriving in that cycle takes priority.
  assign tmo_expire = busy_w && !rx_valid && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (rx_valid || tmo_expire) begin
      tmo_d = '0;
    end else if (busy_w) begin
      tmo_d = tmo_q + 32'd1;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    frame_end_d = 1'b0;
    err_d       = 1'b0;

    if (rx_valid) begin
      word_d = word_next;
      idx_d  = idx_q + 2'd1;
    end

    if (word_ok) begin
      case (state_q)
        S_CMD: begin
          cmd_d   = word_next;
          state_d = S_COUNT;
        end
        S_COUNT: begin
          if (word_next == 32'd0) begin
            frame_end_d = 1'b1;
            state_d     = S_CMD;
          end else if (word_next > 32'(MAX_COUNT)) begin
            err_d   = 1'b1;
            state_d = S_CMD;
          end else begin
            rem_d   = word_next;
            state_d = S_ADDR;
          end
        end
        S_ADDR: begin
          addr_d  = word_next;
          state_d = S_DATA;
        end
        default: begin // S_DATA
          data_d = word_next;
          done_d = 1'b1;
          rem_d  = rem_q - 32'd1;
          if (rem_q == 32'd1) begin
            frame_end_d = 1'b1;
            state_d     = S_CMD;
          end else begin
            state_d = S_ADDR;
          end
        end
      endcase
    end

`ifdef UART_CMD_TIMEOUT_EN
    // Abort discards the partial word; cmd/addr/data keep their values.
    if (tmo_expire) begin
      err_d   = 1'b1;
      idx_d   = 2'd0;
      state_d = S_CMD;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CMD;
      idx_q       <= 2'd0;
      word_q      <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
      frame_end_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      frame_end_q <= frame_end_d;
      err_q       <= err_d;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign cmd       = cmd_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign done      = done_q;
  assign frame_end = frame_end_q;
  assign err       = err_q;
  assign busy      = busy_w;

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  localparam int unsigned MAXC = 256;
  localparam int unsigned TMO  = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] cmd, addr, data;
  logic        done, frame_end, busy, err;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int fe_cnt   = 0;
  int err_cnt  = 0;
  int done_fe_cnt = 0;

  uart_cmd_parser #(.MAX_COUNT(MAXC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd(cmd), .addr(addr), .data(data), .done(done),
    .frame_end(frame_end), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (frame_end) fe_cnt++;
    if (err) err_cnt++;
    if (done && frame_end) done_fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All drive tasks start and end at a negedge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd"}, cmd, 32'h0);
    check({tag, "_addr"}, addr, 32'h0);
    check({tag, "_data"}, data, 32'h0);
    check({tag, "_strobes"}, {29'd0, done, frame_end, err}, 32'h0);
    check({tag, "_busy"}, {31'd0, busy}, 32'h0);
  endtask

  int d0, f0, e0, df0;

  initial begin
    @(negedge clk);
    idle(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle(1);
    check_all_zero("post_reset");

    // CMD byte order, with gaps between bytes
    send_byte(8'h78); idle(2);
    send_byte(8'h56); idle(1);
    send_byte(8'h34); idle(3);
    check("cmd_not_yet", cmd, 32'h0);
    send_byte(8'h12);
    check("cmd_le", cmd, 32'h12345678);
    check("busy_in_count", {31'd0, busy}, 32'd1);

    // COUNT = 0 ends the frame without a pair
    d0 = done_cnt;
    send_word(32'h0);
    check("cnt0_frame_end", {31'd0, frame_end}, 32'd1);
    check("cnt0_done", {31'd0, done}, 32'd0);
    check("cnt0_busy", {31'd0, busy}, 32'd0);
    idle(1);
    check("cnt0_fe_one_cycle", {31'd0, frame_end}, 32'd0);
    check("cnt0_no_done", done_cnt - d0, 0);

    // Main frame: CMD=1, COUNT=4, pairs (i, A0+i)
    d0 = done_cnt; f0 = fe_cnt; e0 = err_cnt; df0 = done_fe_cnt;
    send_word(32'd1);
    send_word(32'd4);
    check("main_cmd", cmd, 32'd1);
    for (int i = 0; i < 4; i++) begin
      send_word(32'(i));
      check($sformatf("main_addr%0d", i), addr, 32'(i));
      check($sformatf("main_nodone_addr%0d", i), {31'd0, done}, 32'd0);
      send_word(32'hA0 + 32'(i));
      check($sformatf("main_done%0d", i), {31'd0, done}, 32'd1);
      check($sformatf("main_data%0d", i), data, 32'hA0 + 32'(i));
      check($sformatf("main_addr_hold%0d", i), addr, 32'(i));
      check($sformatf("main_fe%0d", i), {31'd0, frame_end}, (i == 3) ? 32'd1 : 32'd0);
    end
    idle(1);
    check("main_done_drop", {31'd0, done}, 32'd0);
    check("main_done_cnt", done_cnt - d0, 4);
    check("main_fe_cnt", fe_cnt - f0, 1);
    check("main_done_fe_coinc", done_fe_cnt - df0, 1);
    check("main_err_cnt", err_cnt - e0, 0);
    check("main_busy_end", {31'd0, busy}, 32'd0);
    check("main_data_hold", data, 32'hA3);

    // COUNT = MAX+1 rejected, then a clean frame
    d0 = done_cnt;
    send_word(32'd2);
    send_word(32'(MAXC + 1));
    check("over_err", {31'd0, err}, 32'd1);
    check("over_busy", {31'd0, busy}, 32'd0);
    idle(1);
    check("over_err_one_cycle", {31'd0, err}, 32'd0);
    check("over_no_done", done_cnt - d0, 0);
    send_word(32'd3);
    send_word(32'd1);
    send_word(32'h10);
    send_word(32'hDEADBEEF);
    check("resync_done", {31'd0, done}, 32'd1);
    check("resync_fe", {31'd0, frame_end}, 32'd1);
    check("resync_cmd", cmd, 32'd3);
    check("resync_addr", addr, 32'h10);
    check("resync_data", data, 32'hDEADBEEF);

    // COUNT = 0xFFFFFFFF rejected as unsigned
    send_word(32'd4);
    send_word(32'hFFFF_FFFF);
    check("ffff_err", {31'd0, err}, 32'd1);
    idle(1);

    // COUNT = MAX accepted
    send_word(32'd6);
    send_word(32'(MAXC));
    check("max_no_err", {31'd0, err}, 32'd0);
    check("max_busy", {31'd0, busy}, 32'd1);

    // Reset mid-frame: CMD + 2 bytes of COUNT, reset with a coincident byte
    reset = 1'b1; idle(1); reset = 1'b0;
    send_word(32'd7);
    send_byte(8'h01);
    send_byte(8'h00);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    send_byte(8'h00);
    reset = 1'b0;
    check_all_zero("midrst");
    send_word(32'd5);
    send_word(32'd1);
    send_word(32'd7);
    send_word(32'h55AA);
    check("postrst_done", {31'd0, done}, 32'd1);
    check("postrst_cmd", cmd, 32'd5);
    check("postrst_addr", addr, 32'd7);
    check("postrst_data", data, 32'h55AA);
    idle(1);

    // Eight back-to-back bytes: CMD=9, COUNT=1 (send_word has no gaps)
    send_word(32'd9);
    send_word(32'd1);
    check("b2b_cmd", cmd, 32'd9);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_no_err_fe", {30'd0, err, frame_end}, 32'd0);
    send_word(32'h0102_0304);
    send_word(32'hCAFE_F00D);
    check("b2b_done", {31'd0, done}, 32'd1);
    check("b2b_addr", addr, 32'h0102_0304);
    check("b2b_data", data, 32'hCAFE_F00D);
    idle(1);

`ifdef UART_CMD_TIMEOUT_EN
    e0 = err_cnt;
    send_word(32'hA);
    send_word(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    // A byte in the expiry cycle beats the timeout
    idle(TMO - 1);
    check("tmo_busy_before", {31'd0, busy}, 32'd1);
    send_byte(8'h33);
    check("tmo_rescued", {31'd0, err}, 32'd0);
    check("tmo_rescued_cnt", err_cnt - e0, 0);
    // Now let it expire
    idle(TMO - 1);
    check("tmo_not_yet", {31'd0, err}, 32'd0);
    check("tmo_busy_wait", {31'd0, busy}, 32'd1);
    idle(1);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_busy_clr", {31'd0, busy}, 32'd0);
    check("tmo_cmd_hold", cmd, 32'hA);
    idle(TMO + 5);
    check("tmo_err_once", err_cnt - e0, 1);
    send_word(32'hB);
    send_word(32'd1);
    send_word(32'h20);
    send_word(32'h1234);
    check("tmo_new_done", {31'd0, done}, 32'd1);
    check("tmo_new_cmd", cmd, 32'hB);
    check("tmo_new_addr", addr, 32'h20);
    check("tmo_new_data", data, 32'h1234);
    idle(1);
`else
    // Without the timeout the parser waits indefinitely mid-frame
    send_word(32'hA);
    send_byte(8'h01);
    idle(200);
    check("notmo_busy", {31'd0, busy}, 32'd1);
    check("notmo_err", {31'd0, err}, 32'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_word(32'h20);
    send_word(32'h1234);
    check("notmo_done", {31'd0, done}, 32'd1);
    check("notmo_data", data, 32'h1234);
    idle(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
